// File: rtl/prng_pkg.sv
// Shared types and constants for the PRNG output collector.
package prng_pkg;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, DONE} coll_st_t;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO with synchronous flush.
module sync_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] push_data,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] head
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]       wr_ptr, rd_ptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              pop_ok, push_ok;

  // Extra pointer MSB tells a full FIFO apart from an empty one.
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign head    = mem[rd_ptr[AW-1:0]];
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr[AW-1:0]] <= push_data;
  end
endmodule

// File: rtl/prng_out_collector.sv
// Collects a session of PRNG words into a FIFO for the checker, tracking
// checksum, accepted/dropped counts and overflow.
module prng_out_collector #(
  parameter int DATA_W    = prng_pkg::DATA_W,
  parameter int DEPTH     = 4,
  parameter int NUM_WORDS = 16,
  parameter int CNT_W     = 8
) (
  input  logic                clk3,
  input  logic                rst_n,
  input  logic                start,
  input  logic                in_valid,
  input  logic [DATA_W-1:0]   in_data,
  output logic                out_valid,
  output logic [DATA_W-1:0]   out_data,
  input  logic                out_ready,
  output logic                done,
  output logic                overflow,
  output logic [DATA_W-1:0]   checksum,
  output logic [CNT_W-1:0]    acc_cnt,
  output logic [CNT_W-1:0]    drop_cnt,
  output prng_pkg::coll_st_t  dbg_state
);
  import prng_pkg::*;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_WORDS - 1);

  coll_st_t          state, state_nxt;
  logic              fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_head;
  logic              pop, in_coll, accept, drop;

  // Handshake: a word transfers on any edge where out_valid && out_ready;
  // out_data is stable while out_valid is high and out_ready is low.
  // start wins over both the pending pop and a coincident in_valid.
  assign pop       = out_valid && out_ready && !start;
  assign in_coll   = (state == COLLECT) && in_valid && !start;
  assign accept    = in_coll && (!fifo_full || pop);
  assign drop      = in_coll && fifo_full && !pop;
  assign out_valid = !fifo_empty;
  assign out_data  = fifo_empty ? '0 : fifo_head;
  assign done      = (state == DONE);
  assign dbg_state = state;

  sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk3),
    .rst_n     (rst_n),
    .flush     (start),
    .push      (accept),
    .pop       (pop),
    .push_data (in_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  always_ff @(posedge clk3 or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = COLLECT;
    end else begin
      case (state)
        COLLECT: if (accept && acc_cnt == LAST_CNT) state_nxt = DRAIN;
        DRAIN:   if (fifo_empty) state_nxt = DONE;
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk3 or negedge rst_n) begin
    if (!rst_n) begin
      checksum <= '0;
      acc_cnt  <= '0;
      drop_cnt <= '0;
      overflow <= 1'b0;
    end else if (start) begin
      checksum <= '0;
      acc_cnt  <= '0;
      drop_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      if (accept) begin
        checksum <= checksum ^ in_data;
        acc_cnt  <= acc_cnt + 1'b1;
      end
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_prng_out_collector.sv
// Directed scoreboard bench for prng_out_collector.
module tb_prng_out_collector;
  import prng_pkg::*;

  localparam int DW = 32;
  localparam int CW = 8;

  logic          clk3 = 1'b0;
  logic          rst_n, start, in_valid, out_ready;
  logic [DW-1:0] in_data;
  logic          out_valid, done, overflow;
  logic [DW-1:0] out_data, checksum;
  logic [CW-1:0] acc_cnt, drop_cnt;
  coll_st_t      dbg_state;

  logic [DW-1:0] exp_q[$];
  int            n_checks = 0;
  int            n_fails  = 0;

  prng_out_collector dut (
    .clk3(clk3), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_data(in_data), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .done(done), .overflow(overflow),
    .checksum(checksum), .acc_cnt(acc_cnt), .drop_cnt(drop_cnt),
    .dbg_state(dbg_state)
  );

  // Clock / watchdog
  always #5 clk3 = ~clk3;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clk3);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    exp_q.delete();
    tick();
    start = 1'b0;
  endtask

  task automatic drive_word(input logic [DW-1:0] d, input bit accepted);
    in_valid = 1'b1;
    in_data  = d;
    if (accepted) exp_q.push_back(d);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic check_stats(input string tag, input logic [DW-1:0] cs,
                             input int acc, input int drp, input bit ovf);
    check({tag, "_checksum"}, checksum, cs);
    check({tag, "_acc_cnt"},  DW'(acc_cnt), DW'(acc));
    check({tag, "_drop_cnt"}, DW'(drop_cnt), DW'(drp));
    check({tag, "_overflow"}, DW'(overflow), DW'(ovf));
  endtask

  // Scoreboard monitor: compares every transfer against the expected queue
  always @(negedge clk3) begin
    if (rst_n && out_valid && out_ready && !start) begin
      if (exp_q.size() == 0) check("sb_unexpected_word", out_data, 32'hFFFF_FFFF ^ out_data);
      else check("sb_word", out_data, exp_q.pop_front());
    end
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    #12;
    check("rst_out_valid", DW'(out_valid), 0);
    check("rst_out_data", out_data, 0);
    check("rst_done", DW'(done), 0);
    check("rst_state", DW'(dbg_state), DW'(IDLE));
    check_stats("rst", 0, 0, 0, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Words in IDLE are ignored
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) drive_word(32'h55, 1'b0);
    check("idle_out_valid", DW'(out_valid), 0);
    check_stats("idle", 0, 0, 0, 0);

    // 1: full session streaming straight through
    pulse_start();
    check("t1_state", DW'(dbg_state), DW'(COLLECT));
    for (int i = 1; i <= 16; i++) begin
      drive_word(DW'(i), 1'b1);
      check("t1_latency_valid", DW'(out_valid), 1);
      check("t1_latency_data", out_data, DW'(i));
    end
    check("t1_state_drain", DW'(dbg_state), DW'(DRAIN));
    tick();
    check("t1_done_at_last_pop", DW'(done), 0);
    check("t1_empty", DW'(out_valid), 0);
    tick();
    check("t1_done", DW'(done), 1);
    check_stats("t1", 32'h10, 16, 0, 0);
    check("t1_sb_empty", DW'(exp_q.size()), 0);

    // 6: words in DONE are ignored, stats frozen
    for (int i = 0; i < 4; i++) drive_word(32'h55, 1'b0);
    check("done_out_valid", DW'(out_valid), 0);
    check("done_held", DW'(done), 1);
    check_stats("done", 32'h10, 16, 0, 0);

    // 2: overflow with consumer stalled
    out_ready = 1'b0;
    pulse_start();
    check("t2_done_cleared", DW'(done), 0);
    for (int i = 0; i < 6; i++) drive_word(32'hA0 + DW'(i), i < 4);
    check("t2_head_held", out_data, 32'hA0);
    check_stats("t2", 32'h0, 4, 2, 1);
    out_ready = 1'b1;
    repeat (5) tick();
    check("t2_drained", DW'(out_valid), 0);
    check("t2_no_done", DW'(done), 0);
    check("t2_state", DW'(dbg_state), DW'(COLLECT));
    check("t2_sb_empty", DW'(exp_q.size()), 0);

    // 3: push into a full FIFO on a pop edge
    out_ready = 1'b0;
    pulse_start();
    for (int i = 1; i <= 4; i++) drive_word(32'h30 + DW'(i), 1'b1);
    check("t3_full_no_drop", DW'(drop_cnt), 0);
    out_ready = 1'b1;
    drive_word(32'h35, 1'b1);
    out_ready = 1'b0;
    check_stats("t3_swap", 32'h35 ^ 32'h34 ^ 32'h33 ^ 32'h32 ^ 32'h31, 5, 0, 0);
    drive_word(32'h36, 1'b0);
    check_stats("t3_still_full", 32'h31, 5, 1, 1);
    out_ready = 1'b1;
    repeat (5) tick();
    check("t3_sb_empty", DW'(exp_q.size()), 0);

    // 4: start mid-collect flushes queued words
    out_ready = 1'b0;
    pulse_start();
    for (int i = 1; i <= 3; i++) drive_word(32'h40 + DW'(i), 1'b1);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'h99;
    pulse_start();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("t4_flushed", DW'(out_valid), 0);
    check_stats("t4", 0, 0, 0, 0);
    drive_word(32'hDEAD_BEEF, 1'b1);
    check("t4_first_word", out_data, 32'hDEAD_BEEF);
    check("t4_checksum", checksum, 32'hDEAD_BEEF);
    out_ready = 1'b1;
    repeat (2) tick();
    check("t4_sb_empty", DW'(exp_q.size()), 0);

    // 5: asynchronous reset mid-drain
    pulse_start();
    for (int i = 1; i <= 16; i++) drive_word(DW'(i) * 32'h111, 1'b1);
    out_ready = 1'b0;
    check("t5_state_drain", DW'(dbg_state), DW'(DRAIN));
    check("t5_last_held", out_data, 32'h1110);
    @(negedge clk3);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("t5_out_valid", DW'(out_valid), 0);
    check("t5_out_data", out_data, 0);
    check("t5_state", DW'(dbg_state), DW'(IDLE));
    check("t5_done", DW'(done), 0);
    check_stats("t5", 0, 0, 0, 0);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) drive_word(32'h55, 1'b0);
    check("t5_idle_out_valid", DW'(out_valid), 0);
    check("t5_idle_state", DW'(dbg_state), DW'(IDLE));
    check_stats("t5_idle", 0, 0, 0, 0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
